// File: rtl/dmem_pkg.sv
// Shared definitions for the block data memory and the cache controller that drives it.
package dmem_pkg;

  localparam int unsigned BLOCK_BYTES = 4;
  localparam int unsigned BLOCK_W     = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_e;

  // Request captured when an access is accepted
  typedef struct packed {
    logic               is_write;
    logic [BLOCK_W-1:0] data;
  } dmem_req_t;

endpackage

// File: rtl/block_data_memory_if.sv
// Cache memory-side handshake: level requests held until busywait drops.
interface block_data_memory_if #(
  parameter int unsigned ADDR_W = 6
);
  import dmem_pkg::*;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/dmem_latency_timer.sv
// Loadable down-counter that flags when the access latency has elapsed.
module dmem_latency_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load on accept, count down while enabled, saturate at zero
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block-granular data memory with fixed access latency behind the data cache.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned ADDR_W  = 6
) (
  input logic                 clock,
  input logic                 reset,
  block_data_memory_if.slave  bus
);

  localparam int unsigned CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned DEPTH_BYTES = BLOCK_BYTES << ADDR_W;
  localparam int unsigned BYTE_AW     = ADDR_W + 2;

  dmem_state_e        state_q, state_d;
  dmem_req_t          req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] readdata_q;
  logic [7:0]         mem [DEPTH_BYTES];

  logic               busywait_c;
  logic               accept_c;
  logic               execute_c;
  logic               timer_zero;
  logic [BYTE_AW-1:0] base_c;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accept/execute strobes and busywait
  always_comb begin
    state_d    = state_q;
    busywait_c = 1'b0;
    accept_c   = 1'b0;
    execute_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          busywait_c = 1'b1;
          accept_c   = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busywait_c = 1'b1;
        if (timer_zero) begin
          execute_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  dmem_latency_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (accept_c),
    .load_value (CNT_W'(LATENCY - 1)),
    .enable     (state_q == BUSY),
    .zero       (timer_zero)
  );

  assign base_c = {addr_q, 2'b00};

  // Request latch, byte array and read data register
  always_ff @(posedge clock) begin
    if (!reset) begin
      req_q      <= '0;
      addr_q     <= '0;
      readdata_q <= '0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (accept_c) begin
        req_q.is_write <= bus.mem_write;
        req_q.data     <= bus.mem_writedata;
        addr_q         <= bus.mem_address;
      end
      if (execute_c) begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (req_q.is_write) begin
            mem[base_c | BYTE_AW'(i)] <= req_q.data[8*i +: 8];
          end else begin
            readdata_q[8*i +: 8] <= mem[base_c | BYTE_AW'(i)];
          end
        end
      end
    end
  end

  assign bus.mem_readdata = readdata_q;
  assign bus.mem_busywait = busywait_c;

endmodule
